// File: rtl/vga_scan.sv
// vga_scan: VGA timing generator that shows a 256x256 pixel buffer window, gated per frame by buffer completion
module vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_X0   = 192,
    parameter int IMG_Y0   = 112
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        complete,
    output logic [15:0] vga_addr,
    input  logic [7:0]  vga_data,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_done
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          disp_en_q, disp_en_d;
    logic          frame_done_q, frame_done_d;
    logic [3:0]    colour_q, colour_d;
    logic [31:0]   h_x, v_y;
    logic          h_last, wrap, in_img, active, hs_n, vs_n;

    // Decode the current counter position into window, active-area and sync flags plus the buffer address
    always_comb begin
        h_x      = 32'(h_cnt_q);
        v_y      = 32'(v_cnt_q);
        h_last   = h_cnt_q == H_LAST;
        wrap     = h_last && v_cnt_q == V_LAST;
        in_img   = h_x >= IMG_X0 && h_x < IMG_X0 + 256 && v_y >= IMG_Y0 && v_y < IMG_Y0 + 256;
        active   = h_x < H_ACTIVE && v_y < V_ACTIVE;
        hs_n     = !(h_x >= H_ACTIVE + H_FP && h_x < H_ACTIVE + H_FP + H_SYNC);
        vs_n     = !(v_y >= V_ACTIVE + V_FP && v_y < V_ACTIVE + V_FP + V_SYNC);
        vga_addr = in_img ? {8'(v_y - 32'(IMG_Y0)), 8'(h_x - 32'(IMG_X0))} : 16'h0000;
    end

    // Next state: advance counters and capture this pixel's sync/colour on each pixel enable
    always_comb begin
        h_cnt_d      = pix_en ? (h_last ? '0 : h_cnt_q + HW'(1)) : h_cnt_q;
        v_cnt_d      = (pix_en && h_last) ? (wrap ? '0 : v_cnt_q + VW'(1)) : v_cnt_q;
        hsync_d      = pix_en ? hs_n : hsync_q;
        vsync_d      = pix_en ? vs_n : vsync_q;
        colour_d     = pix_en ? ((in_img && active && disp_en_q) ? vga_data[7:4] : 4'h0) : colour_q;
        disp_en_d    = (pix_en && wrap) ? complete : disp_en_q;
        frame_done_d = pix_en && wrap;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            colour_q     <= 4'h0;
            disp_en_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            colour_q     <= colour_d;
            disp_en_q    <= disp_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign red        = colour_q;
    assign green      = colour_q;
    assign blue       = colour_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: reduced-geometry VGA scan bench with a pixel-index reference model
module tb_vga_scan;
    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int X0 = 10, Y0 = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic        complete = 1'b0;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        hsync, vsync, frame_done;
    logic [3:0]  red, green, blue;

    int          mode = 0;
    logic [7:0]  rtab [256];
    int          p = 0;
    int          frames = 0;
    logic        disp = 1'b0;
    logic        exp_hs = 1'b1, exp_vs = 1'b1;
    logic [3:0]  exp_col = 4'h0;
    int          total = 0, bad = 0;
    int          fd_seen = 0;

    vga_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_X0(X0), .IMG_Y0(Y0)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .complete(complete),
        .vga_addr(vga_addr), .vga_data(vga_data),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return mode == 0 ? a[7:0] : mode == 1 ? 8'hFF : rtab[a[7:0] ^ a[15:8]];
    endfunction

    always @(posedge clk) vga_data <= mem_rd(vga_addr);

    always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

    function automatic logic in_win(input int pos);
        int h, v;
        h = pos % HT;
        v = pos / HT;
        return h >= X0 && h < X0 + 256 && v >= Y0 && v < Y0 + 256;
    endfunction

    function automatic logic [15:0] addr_of(input int pos);
        return in_win(pos) ? {8'((pos / HT) - Y0), 8'((pos % HT) - X0)} : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h pos=%0d frame=%0d", tag, obs, exp, p, frames);
        end
    endtask

    task automatic check_outs(input logic fd_exp);
        chk("hsync", 16'(hsync), 16'(exp_hs));
        chk("vsync", 16'(vsync), 16'(exp_vs));
        chk("red", 16'(red), 16'(exp_col));
        chk("green", 16'(green), 16'(exp_col));
        chk("blue", 16'(blue), 16'(exp_col));
        chk("frame_done", 16'(frame_done), 16'(fd_exp));
        chk("vga_addr", vga_addr, addr_of(p));
    endtask

    task automatic tick(input int gap);
        int h, v;
        logic [7:0] d;
        logic fd;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        h = p % HT;
        v = p / HT;
        d = mem_rd(addr_of(p));
        exp_hs = !(h >= HA + HF && h < HA + HF + HS);
        exp_vs = !(v >= VA + VF && v < VA + VF + VS);
        exp_col = (in_win(p) && h < HA && v < VA && disp) ? d[7:4] : 4'h0;
        fd = p == FR - 1;
        if (fd) begin
            disp = complete;
            frames++;
        end
        p = (p + 1) % FR;
        check_outs(fd);
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            check_outs(1'b0);
        end
    endtask

    task automatic run_to(input int f, input int pos);
        while (frames < f || (frames == f && p < pos)) tick(int'($urandom_range(2, 3)));
    endtask

    initial begin
        int fb;
        for (int i = 0; i < 256; i++) rtab[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        chk("rst_hsync", 16'(hsync), 16'h1);
        chk("rst_vsync", 16'(vsync), 16'h1);
        chk("rst_red", 16'(red), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        chk("rst_addr", vga_addr, 16'h0000);
        rst = 1'b1;
        run_to(0, (Y0 + 3) * HT + X0 + 21);
        chk("f0_black", 16'(red), 16'h0);
        run_to(0, 20 * HT);
        complete = 1'b1;
        run_to(1, Y0 * HT + X0 + 1);
        chk("f1_origin_col", 16'(red), 16'h0);
        chk("f1_addr_01", vga_addr, 16'h0001);
        run_to(1, (Y0 + 3) * HT + X0 + 21);
        chk("f1_col_14", 16'(red), 16'h1);
        chk("f1_addr_315", vga_addr, 16'h0315);
        run_to(1, 20 * HT);
        complete = 1'b0;
        run_to(1, 25 * HT + X0 + 21);
        chk("f1_kept_up", 16'(red), 16'h1);
        run_to(2, 10 * HT + X0 + 21);
        chk("f2_black", 16'(red), 16'h0);
        mode = 1;
        complete = 1'b1;
        @(negedge clk);
        run_to(3, Y0 * HT + X0);
        chk("ff_left_out", 16'(red), 16'h0);
        tick(2);
        chk("ff_left_in", 16'(red), 16'hF);
        run_to(3, Y0 * HT + HA);
        chk("ff_right_in", 16'(blue), 16'hF);
        tick(2);
        chk("ff_right_out", 16'(green), 16'h0);
        run_to(3, 10 * HT + HA + HF);
        chk("hs_before", 16'(hsync), 16'h1);
        tick(2);
        chk("hs_first", 16'(hsync), 16'h0);
        run_to(3, 10 * HT + HA + HF + HS);
        chk("hs_last", 16'(hsync), 16'h0);
        tick(2);
        chk("hs_after", 16'(hsync), 16'h1);
        mode = 2;
        @(negedge clk);
        repeat (FR + FR / 2) begin
            if ($urandom_range(0, 299) == 0) complete = ~complete;
            tick(int'($urandom_range(2, 3)));
        end
        complete = 1'b1;
        fb = frames;
        run_to(fb + 1, (VA + VF) * HT + HA + HF + 2);
        chk("pre_rst_hs", 16'(hsync), 16'h0);
        chk("pre_rst_vs", 16'(vsync), 16'h0);
        rst = 1'b0;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        chk("mid_rst_hs", 16'(hsync), 16'h1);
        chk("mid_rst_vs", 16'(vsync), 16'h1);
        chk("mid_rst_col", 16'(red), 16'h0);
        chk("mid_rst_fd", 16'(frame_done), 16'h0);
        repeat (2) @(negedge clk);
        chk("mid_rst_addr", vga_addr, 16'h0000);
        rst = 1'b1;
        p = 0;
        disp = 1'b0;
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        exp_col = 4'h0;
        fb = frames;
        run_to(fb + 1, (Y0 + 2) * HT);
        repeat (4) @(negedge clk);
        chk("fd_count", 16'(fd_seen), 16'(frames));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in pixels; line total 800.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch in lines; frame total 525.
REQ-005 Parameter IMG_X0 / IMG_Y0, 192 / 112, top-left screen coordinate of the 256x256 image window.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 pix_en  input  1  pixel-clock enable, one clk wide; all counters and output registers advance only on clk edges with pix_en=1.
REQ-009 complete  input  1  high when the pixel buffer has been fully written and may be displayed.
REQ-010 vga_addr  output  16  pixel buffer read address {row[7:0], col[7:0]}.
REQ-011 vga_data  input  8  pixel buffer read data, valid one clk after vga_addr changes (synchronous BRAM).
REQ-012 hsync / vsync  output  1 each  active-low sync pulses.
REQ-013 red / green / blue  output  4 each  colour outputs.
REQ-014 frame_done  output  1  one-clk pulse at end of each frame.

Function
REQ-015 h_cnt counts 0..799 on each pix_en; on 799 it wraps to 0 and v_cnt increments; v_cnt counts 0..524 and wraps to 0.
REQ-016 Pixel stage hsync_n = 0 iff 656 <= h_cnt <= 751; vsync_n = 0 iff 490 <= v_cnt <= 491.
REQ-017 in_img = 1 iff IMG_X0 <= h_cnt < IMG_X0+256 and IMG_Y0 <= v_cnt < IMG_Y0+256.
REQ-018 vga_addr is combinational from the counters: {(v_cnt-IMG_Y0)[7:0], (h_cnt-IMG_X0)[7:0]} when in_img=1, else 16'h0000; stable for the whole pix_en period.
REQ-019 Outputs are registered on pix_en and lag the counters by exactly one pixel period; hsync, vsync and colour are delayed together and stay aligned.
REQ-020 Registered colour: red = green = blue = vga_data[7:4] when the delayed in_img=1 and disp_en=1, else 4'h0.
REQ-021 disp_en register: loaded from complete only on the pix_en edge where h_cnt=799 and v_cnt=524; a complete change mid-frame never alters the frame in progress.
REQ-022 frame_done = 1 for exactly one clk, on the pix_en edge where the counters wrap from (799,524) to (0,0); otherwise 0.
REQ-023 Colour outside the 640x480 active region is always 4'h0, whatever vga_data is.
REQ-024 With pix_en held 0: counters, outputs and disp_en hold; frame_done stays 0.
REQ-025 pix_en pulses are at least 2 clk apart; vga_data sampled on the next pix_en edge is then valid.

Reset
REQ-026 On a clk edge with rst=0: h_cnt=0, v_cnt=0, disp_en=0, hsync=1, vsync=1, red/green/blue=0, frame_done=0; pix_en is ignored.
REQ-027 Reset mid-frame restarts timing at (0,0) on the first pix_en edge after rst returns high; no partial sync pulse remains asserted.

Verification
REQ-028 Reset, then pix_en every 4th clk for 2 frames -> hsync low for 96 pixels per 800, vsync low for 2 lines per 525, frame_done every 420000 pix_en ticks.
REQ-029 complete=1 before frame 1 ends, BRAM model data = addr[7:0] -> in frame 2, screen (192,112) shows colour 0 with vga_addr=16'h0000; (447,367) shows vga_addr=16'hFFFF, colour 4'hF.
REQ-030 complete=0 throughout -> all colour outputs 0 for all pixels; syncs still toggle normally.
REQ-031 complete goes 1 at v_cnt=200 -> the current frame stays black; the next frame shows the image; complete drops mid-frame -> the image stays up until that frame ends.
REQ-032 rst=0 asserted at h_cnt=700, v_cnt=490 for 3 clk -> hsync=vsync=1 and colour 0 immediately; the counters restart from (0,0).
REQ-033 BRAM data 8'hFF at every address, screen pixel (191,112) and (640,112) -> colour 0 at both; pixel (192,112) -> 4'hF.
